// File: rtl/clk_switch_pkg.sv
// Shared definitions for the clock-switch controller: FSM state encoding and
// clock source identifiers.
package clk_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ARM    = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

    // Picks the gate-enable status that belongs to a given source.
    function automatic logic src_en(input logic src, input logic ena, input logic enb);
        return (src == SRC_A) ? ena : enb;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous level input.
// The depth is a parameter; the chain clears to 0 on reset.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequencer for a glitch-free clock switch: it drives the select, waits for the
// old gate to close and the new gate to open, then lets the new clock settle.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no switch in progress, ready for a request
// ST_DRAIN  | select changed, waiting for the old source gate to close
// ST_ARM    | waiting for the new source gate to open
// ST_SETTLE | new source running, counting out the settle time
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   SETTLE_CYC  = 4,
    parameter int   TIMEOUT_CYC = 1024,
    parameter logic RST_SRC     = SRC_A
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_src,
    output logic req_ready,
    output logic sw_sel,
    input  logic en_a_stat,
    input  logic en_b_stat,
    output logic cur_src,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_HIT  = TMO_W'(TIMEOUT_CYC - 2);

    state_t             state;
    logic [SET_W-1:0]   set_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_nxt;
    logic               tmo_hit;
    logic               ena_s;
    logic               enb_s;
    logic               old_en;
    logic               new_en;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (en_a_stat),
        .q     (ena_s)
    );

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (en_b_stat),
        .q     (enb_s)
    );

    assign old_en    = src_en(cur_src, ena_s, enb_s);
    assign new_en    = src_en(sw_sel, ena_s, enb_s);
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // The counter saturates at TIMEOUT_CYC-1; the hit fires on the edge that
    // reaches it, or on any later edge if a DRAIN exit landed exactly there.
    assign tmo_nxt = (tmo_cnt == TMO_LAST) ? tmo_cnt : tmo_cnt + 1'b1;
    assign tmo_hit = (tmo_cnt >= TMO_HIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sw_sel  <= RST_SRC;
            cur_src <= RST_SRC;
            done    <= 1'b0;
            err     <= 1'b0;
            set_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_src == cur_src) begin
                            done <= 1'b1;
                        end else begin
                            sw_sel  <= req_src;
                            tmo_cnt <= '0;
                            state   <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    tmo_cnt <= tmo_nxt;
                    if (!old_en) begin
                        state <= ST_ARM;
                    end else if (tmo_hit) begin
                        err    <= 1'b1;
                        sw_sel <= cur_src;
                        state  <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    tmo_cnt <= tmo_nxt;
                    if (new_en) begin
                        set_cnt <= '0;
                        state   <= ST_SETTLE;
                    end else if (tmo_hit) begin
                        err    <= 1'b1;
                        sw_sel <= cur_src;
                        state  <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (set_cnt == SET_LAST) begin
                        cur_src <= sw_sel;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: directed corner cases followed by
// randomized switch sequences checked against an edge-timing reference model.
module tb_clk_switch_ctrl;

    localparam int SYNC   = 2;
    localparam int SETTLE = 4;
    localparam int TMO    = 16;
    localparam int BIG    = 1000;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid;
    logic req_src;
    logic req_ready;
    logic sw_sel;
    logic en_a_stat;
    logic en_b_stat;
    logic cur_src;
    logic busy;
    logic done;
    logic err;

    int   n_vec  = 0;
    int   n_miss = 0;
    logic m_cur;

    always #5 clk = ~clk;

    clk_switch_ctrl #(
        .SYNC_STAGES (SYNC),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO),
        .RST_SRC     (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_src   (req_src),
        .req_ready (req_ready),
        .sw_sel    (sw_sel),
        .en_a_stat (en_a_stat),
        .en_b_stat (en_b_stat),
        .cur_src   (cur_src),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    task automatic set_en(input logic src, input logic val);
        if (src) en_a_stat = val;
        else     en_b_stat = val;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edge numbering: the accepting edge is 0. An enable changed just after
    // edge k is visible to the FSM at edge k+SYNC+1. tf/tr < 0 means never.
    task automatic run_switch(input logic new_src, input int tf, input int tr, input bit pulse);
        int d, a, tmo_e, exp_done, exp_err, got_done, got_err, n_pulse, last;
        bit same, busy_seen, hold;
        same     = (new_src == m_cur);
        exp_done = -1;
        exp_err  = -1;
        a        = BIG;
        if (same) begin
            exp_done = 0;
        end else begin
            d     = (tf < 0) ? BIG : max2(1, tf + SYNC + 1);
            a     = (tr < 0) ? BIG : max2(d + 1, tr + SYNC + 1);
            tmo_e = (d > TMO - 1) ? TMO - 1 : max2(TMO - 1, d + 1);
            if (a <= tmo_e) exp_done = a + SETTLE;
            else            exp_err  = tmo_e;
        end
        last      = max2(exp_done, exp_err) + 3;
        hold      = pulse && (exp_done > 0);
        got_done  = -1;
        got_err   = -1;
        n_pulse   = 0;
        busy_seen = 1'b0;
        req_src   = new_src;
        req_valid = 1'b1;
        for (int e = 0; e <= last; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) req_valid = 1'b0;
            if (done) begin
                n_pulse++;
                if (got_done < 0) got_done = e;
            end
            if (err) begin
                n_pulse++;
                if (got_err < 0) got_err = e;
            end
            busy_seen = busy_seen | busy;
            chk("done_err_excl", int'(done && err), 0);
            if (e == 0 && !same) begin
                chk("sw_sel_accept", sw_sel, new_src);
                chk("busy_accept", busy, 1);
            end
            if (hold) begin
                if (e == a + 2 || e == a + 3) chk("settle_req_ignored", sw_sel, new_src);
                if (e == a + 1) begin
                    req_valid = 1'b1;
                    req_src   = ~new_src;
                end
                if (e == a + 2) req_valid = 1'b0;
                if (e == a + 3) req_valid = 1'b1;
            end
            if (!same && got_err < 0 && got_done < 0) begin
                if (e == tf) set_en(m_cur, 1'b0);
                if (e == tr) set_en(new_src, 1'b1);
            end
            if (hold && got_done >= 0) break;
        end
        chk("done_edge", got_done, exp_done);
        chk("err_edge", got_err, exp_err);
        chk("pulse_count", n_pulse, 1);
        if (same) chk("same_no_busy", busy_seen, 0);
        if (exp_done >= 0) m_cur = new_src;
        chk("cur_src", cur_src, m_cur);
        chk("sw_sel_final", sw_sel, m_cur);
        if (!hold) begin
            set_en(m_cur, 1'b1);
            set_en(~m_cur, 1'b0);
            idle_cycles(SYNC + 3);
        end
    endtask

    initial begin
        int pulses;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_src   = 1'b1;
        en_a_stat = 1'b1;
        en_b_stat = 1'b0;
        m_cur     = 1'b1;
        #12;
        chk("rst_sw_sel", sw_sel, 1);
        chk("rst_cur_src", cur_src, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", req_ready, 1);
        idle_cycles(SYNC + 2);

        // Same source: immediate done, no busy.
        run_switch(1'b1, 0, 0, 1'b0);

        // A->B with known timing, request pulsed then held during SETTLE,
        // followed by the held B->A request accepted right after done.
        run_switch(1'b0, 3, 6, 1'b1);
        run_switch(1'b1, 2, 5, 1'b0);

        // New gate never opens: timeout and revert.
        run_switch(1'b0, 1, -1, 1'b0);

        // Reset asserted while waiting in ARM.
        req_src   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        en_a_stat = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("arm_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_sw_sel", sw_sel, 1);
        chk("arst_cur_src", cur_src, 1);
        chk("arst_req_ready", req_ready, 1);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        en_a_stat = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            pulses += int'(done) + int'(err);
        end
        chk("arst_no_pulse", pulses, 0);
        chk("arst_ready", req_ready, 1);
        m_cur = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic ns;
            int   tf;
            int   tr;
            ns = 1'($urandom_range(0, 1));
            tf = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 12));
            tr = ($urandom_range(0, 3) == 0) ? -1 : tf + int'($urandom_range(1, 6));
            run_switch(ns, tf, tr, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth for switch status inputs (legal 2..4).
REQ-002 Parameter: SETTLE_CYC, 4, clk cycles to wait after the new source is confirmed on (legal 1..255).
REQ-003 Parameter: TIMEOUT_CYC, 1024, max clk cycles from request acceptance to new source confirmed (legal 16..65535).
REQ-004 Parameter: RST_SRC, 1, source selected at reset (1 = clk_a, 0 = clk_b).
REQ-005 Port: clk  input  1  controller clock, always running, independent of both switched clocks.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: req_valid  input  1  switch request valid.
REQ-008 Port: req_src  input  1  requested source (1 = clk_a, 0 = clk_b).
REQ-009 Port: req_ready  output  1  controller can accept a request.
REQ-010 Port: sw_sel  output  1  select driven to the glitch-free clock switch.
REQ-011 Port: en_a_stat  input  1  clk_a gate-enable status from the switch, asynchronous to clk.
REQ-012 Port: en_b_stat  input  1  clk_b gate-enable status from the switch, asynchronous to clk.
REQ-013 Port: cur_src  output  1  last successfully confirmed source.
REQ-014 Port: busy  output  1  switch sequence in progress.
REQ-015 Port: done  output  1  one-cycle pulse, switch completed.
REQ-016 Port: err  output  1  one-cycle pulse, switch timed out.

Function
REQ-017 en_a_stat/en_b_stat SHALL each pass a SYNC_STAGES-flop synchronizer before any use; only synchronized values (ena_s, enb_s) feed the FSM.
REQ-018 FSM states: IDLE, DRAIN, ARM, SETTLE; encoding from shared package.
REQ-019 req_ready = 1 only in IDLE; busy = not IDLE; request accepted on edge where req_valid && req_ready.
REQ-020 Accept with req_src == cur_src: no sw_sel change, done pulses the following cycle, FSM stays IDLE.
REQ-021 Accept with req_src != cur_src: sw_sel <= req_src on the accepting edge, timeout counter cleared, FSM -> DRAIN.
REQ-022 DRAIN: wait until synchronized enable of old source (cur_src) is 0, then -> ARM.
REQ-023 ARM: wait until synchronized enable of new source (sw_sel) is 1, then settle counter cleared, -> SETTLE.
REQ-024 SETTLE: count SETTLE_CYC cycles; at terminal count cur_src <= sw_sel, done pulses one cycle, -> IDLE.
REQ-025 Timeout counter increments every cycle in DRAIN and ARM; on reaching TIMEOUT_CYC-1: err pulses one cycle, sw_sel <= cur_src (revert), cur_src unchanged, -> IDLE; counter saturates, never wraps.
REQ-026 Timeout and a same-cycle DRAIN/ARM exit condition: exit condition wins, no err.
REQ-027 done and err SHALL never be high in the same cycle; each is high at most one cycle per request.
REQ-028 req_valid while busy is ignored (not queued); requester must hold req_valid until accepted.
REQ-029 Counters sized $clog2 of their parameter; no arithmetic overflow at max parameter values.

Reset
REQ-030 rst_n low asynchronously forces: FSM IDLE, sw_sel = RST_SRC, cur_src = RST_SRC, done = 0, err = 0, counters 0, synchronizer flops 0.
REQ-031 req_ready SHALL read 1 from the first clk edge after rst_n deasserts; reset mid-sequence aborts it with no done/err pulse.

Structure
REQ-032 Package clk_switch_pkg holds FSM state typedef/encodings and source constants SRC_A = 1, SRC_B = 0.
REQ-033 One sub-module sync_2ff (parameterized depth, async active-low reset), instantiated once per status input.

Verification
REQ-034 Reset, RST_SRC=1 -> sw_sel=1, cur_src=1, req_ready=1, done=err=0.
REQ-035 req_src=0 accepted at cycle 0; en_a_stat falls at cycle 3, en_b_stat rises at cycle 6 -> sw_sel=0 from cycle 1, done at cycle 6+2+4 (sync + SETTLE) ±1, cur_src=0 after done.
REQ-036 req_src equal to cur_src -> done at next cycle, sw_sel unchanged, busy never asserted.
REQ-037 TIMEOUT_CYC=16, en_b_stat held 0 after request for clk_b -> err at cycle 15 after accept, sw_sel reverts to 1, cur_src stays 1, no done.
REQ-038 rst_n asserted during ARM -> all outputs to reset values immediately; no done/err pulse.
REQ-039 req_valid pulsed during SETTLE -> ignored; held req_valid accepted on first cycle after done.
